// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: double-dabble binary to six-digit BCD converter, one bit per clock.
module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin_in,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [3:0]          bcd0,
  output logic [3:0]          bcd1,
  output logic [3:0]          bcd2,
  output logic [3:0]          bcd3,
  output logic [3:0]          bcd4,
  output logic [3:0]          bcd5
);
  localparam int unsigned MAX_VAL = 999999;
  localparam int CW = $clog2(IN_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, PUBLISH} state_t;
  state_t state, state_nxt;
  logic [IN_WIDTH-1:0] sr;
  logic [23:0] acc, acc_adj;
  logic [CW-1:0] cnt;
  logic ovf_pend;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE && start) ? SHIFT :
                (state == SHIFT && cnt == CW'(1)) ? PUBLISH :
                (state == PUBLISH) ? IDLE : state;
  always_comb busy = state != IDLE;
  // all nibbles are corrected in parallel from the pre-add accumulator
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < 6; i++)
      acc_adj[4*i +: 4] = (acc[4*i +: 4] >= 4'd5) ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      ovf_pend <= 1'b0;
      done <= 1'b0;
      overflow <= 1'b0;
      {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0} <= '0;
    end else begin
      done <= state == PUBLISH;
      if (state == IDLE && start) begin
        sr <= bin_in;
        acc <= '0;
        cnt <= CW'(IN_WIDTH);
        ovf_pend <= 32'(bin_in) > MAX_VAL;
      end
      if (state == SHIFT) begin
        acc <= {acc_adj[22:0], sr[IN_WIDTH-1]};
        sr <= sr << 1;
        cnt <= cnt - CW'(1);
      end
      if (state == PUBLISH) begin
        overflow <= ovf_pend;
        {bcd5, bcd4, bcd3, bcd2, bcd1, bcd0} <= ovf_pend ? 24'h999999 : acc;
      end
    end
endmodule
